reset_sequencer: RTL and testbench

Parametrised reset controller that replaces the fixed 8-cycle power-on shift register and the hand-ANDed reset terms in the board top levels. It synchronises N active-low reset request sources, optionally debounces selected ones (push-buttons), and enforces a power-on hold and a minimum reset-stretch. It drives a single glitch-free active-low core reset and records which source caused the last reset. It sits in the CPU clock domain, between the keyboard/button pins and the core's reset input.

---
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises and optionally debounces active-low reset
// requests, applies a power-on hold and a minimum reset stretch, and drives a
// registered, glitch-free active-low core reset. It also records which
// sources caused the most recent reset.
module reset_sequencer #(
  parameter int                 NUM_SRC         = 3,
  parameter int                 POR_CYCLES      = 8,
  parameter int                 STRETCH_CYCLES  = 16,
  parameter int                 DEBOUNCE_CYCLES = 65536,
  parameter logic [NUM_SRC-1:0] DEBOUNCE_MASK   = NUM_SRC'(3'b100)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req_n,
  input  logic               cause_clr,
  output logic               rst_n,
  output logic               rst_active,
  output logic               por_done,
  output logic               por_cause,
  output logic [NUM_SRC-1:0] cause
);

  // The phase counter is shared by POR and STRETCH. It is cleared on every
  // state entry, so sizing it for the larger of the two phases is sufficient.
  localparam int CNT_MAX = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_POR,
    ST_HOLD,
    ST_STRETCH,
    ST_RUN
  } state_t;

  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;
  logic [NUM_SRC-1:0] filt;
  logic [NUM_SRC-1:0] act;
  logic               any;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rst_n_q;
  logic               rst_active_q;
  logic               por_done_q, por_done_d;
  logic               por_cause_q, por_cause_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] cause_set;

  // Two-flop synchroniser on every request line. It idles high (inactive).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= req_n;
      sync2_q <= sync1_q;
    end
  end

  // Per-source filtering. Button inputs must hold a new level for
  // DEBOUNCE_CYCLES consecutive samples before the filter follows them. All
  // other inputs pass straight through after synchronisation.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    if (DEBOUNCE_MASK[gi]) begin : g_deb
      logic            filt_q;
      logic [DB_W-1:0] db_cnt_q;

      // The stability counter runs only while the input disagrees with the
      // filter. Any agreement resets it, so short glitches are never seen.
      always_ff @(posedge clk) begin
        if (reset) begin
          filt_q   <= 1'b1;
          db_cnt_q <= '0;
        end else if (sync2_q[gi] == filt_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_q   <= sync2_q[gi];
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end

      assign filt[gi] = filt_q;
    end else begin : g_pass
      assign filt[gi] = sync2_q[gi];
    end
  end

  assign act = ~filt;
  assign any = |act;

  // Next-state logic for the sequencer, plus the sticky status bits that
  // depend on it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    cause_set = '0;
    unique case (state_q)
      ST_POR: begin
        // Requests are ignored here; the front end keeps sampling them.
        if (cnt_q == CNT_W'(POR_CYCLES - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        cnt_d = '0;
        if (!any) begin
          state_d = ST_STRETCH;
        end
      end
      ST_STRETCH: begin
        // A new request discards the partial stretch. The full stretch then
        // restarts after that request releases.
        if (any) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (any) begin
          state_d   = ST_HOLD;
          cause_set = act;
        end
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase

    // New cause bits win over a simultaneous clear. Older bits are dropped.
    cause_d     = (cause_clr ? '0 : cause_q) | cause_set;
    por_cause_d = por_cause_q & ~cause_clr;
    por_done_d  = por_done_q | ((state_q == ST_POR) && (state_d != ST_POR));
  end

  // State register. The reset outputs are registered from the next state so
  // that they are glitch-free and line up with the state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_POR;
      cnt_q        <= '0;
      rst_n_q      <= 1'b0;
      rst_active_q <= 1'b1;
      por_done_q   <= 1'b0;
      por_cause_q  <= 1'b1;
      cause_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_n_q      <= (state_d == ST_RUN);
      rst_active_q <= (state_d != ST_RUN);
      por_done_q   <= por_done_d;
      por_cause_q  <= por_cause_d;
      cause_q      <= cause_d;
    end
  end

  assign rst_n      = rst_n_q;
  assign rst_active = rst_active_q;
  assign por_done   = por_done_q;
  assign por_cause  = por_cause_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer. The expected values are
// hand-derived edge counts for NUM_SRC=3, POR=8, STRETCH=16, DEBOUNCE=4,
// MASK=3'b100.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_n;
  logic       cause_clr;
  logic       rst_n;
  logic       rst_active;
  logic       por_done;
  logic       por_cause;
  logic [2:0] cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_SRC        (3),
    .POR_CYCLES     (8),
    .STRETCH_CYCLES (16),
    .DEBOUNCE_CYCLES(4),
    .DEBOUNCE_MASK  (3'b100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_n     (req_n),
    .cause_clr (cause_clr),
    .rst_n     (rst_n),
    .rst_active(rst_active),
    .por_done  (por_done),
    .por_cause (por_cause),
    .cause     (cause)
  );

  // Advance one clock edge. Outputs are then sampled and inputs are driven
  // 1 time unit after that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".rst_n"},      8'(rst_n),      8'h00);
    check({tag, ".rst_active"}, 8'(rst_active), 8'h01);
    check({tag, ".por_done"},   8'(por_done),   8'h00);
    check({tag, ".por_cause"},  8'(por_cause),  8'h01);
    check({tag, ".cause"},      8'(cause),      8'h00);
  endtask

  // Edge 1 is the first edge with reset low. rst_n rises at edge 25, and
  // por_done rises at edge 8.
  task automatic power_up(input string tag);
    for (int e = 1; e <= 25; e++) begin
      step();
      check($sformatf("%s.rst_n@%0d", tag, e),      8'(rst_n),      8'(e >= 25));
      check($sformatf("%s.rst_active@%0d", tag, e), 8'(rst_active), 8'(e < 25));
      check($sformatf("%s.por_done@%0d", tag, e),   8'(por_done),   8'(e >= 8));
    end
    check({tag, ".por_cause"}, 8'(por_cause), 8'h01);
    check({tag, ".cause"},     8'(cause),     8'h00);
    $display("txn %s: power-up sequence checked", tag);
  endtask

  initial begin
    reset     = 1'b1;
    req_n     = 3'b111;
    cause_clr = 1'b0;

    // Hard reset state
    repeat (3) step();
    check_reset_values("rst");
    $display("txn rst: reset values checked");

    // Power-up with no requests
    reset = 1'b0;
    power_up("pwr");

    // Debounced source glitch of 3 cycles: must be filtered out
    for (int e = 1; e <= 12; e++) begin
      req_n[2] = (e <= 3) ? 1'b0 : 1'b1;
      step();
      check($sformatf("glitch.rst_n@%0d", e), 8'(rst_n), 8'h01);
    end
    check("glitch.cause", 8'(cause), 8'h00);
    $display("txn glitch: 3-cycle glitch on debounced source ignored");

    // Debounced source held low for 10 cycles. The filter flips at edge 6,
    // so rst_n falls at edge 7. The filter releases at edge 16, so rst_n
    // rises at edge 33.
    for (int e = 1; e <= 33; e++) begin
      req_n[2] = (e <= 10) ? 1'b0 : 1'b1;
      step();
      check($sformatf("deb.rst_n@%0d", e),      8'(rst_n),      8'(e < 7 || e >= 33));
      check($sformatf("deb.rst_active@%0d", e), 8'(rst_active), 8'(e >= 7 && e < 33));
      if (e == 7) check("deb.cause", 8'(cause), 8'h04);
    end
    check("deb.por_cause", 8'(por_cause), 8'h01);
    $display("txn deb: debounced request reset checked");

    // cause_clr coincides with RUN->HOLD from req_n[0] at edge 3. The new
    // bit survives, and the old bit and por_cause clear.
    for (int e = 1; e <= 20; e++) begin
      req_n[0]  = (e == 1) ? 1'b0 : 1'b1;
      cause_clr = (e == 3);
      step();
      check($sformatf("clr.rst_n@%0d", e), 8'(rst_n), 8'(e < 3 || e >= 20));
      if (e == 3) begin
        check("clr.cause",     8'(cause),     8'h01);
        check("clr.por_cause", 8'(por_cause), 8'h00);
      end
    end
    check("clr.cause_end", 8'(cause), 8'h01);
    $display("txn clr: set-beats-clear on cause checked");

    // The 1-cycle req_n[0] pulse enters STRETCH at edge 4. A req_n[1] pulse
    // is seen while the stretch count is 10, which sends the sequencer back
    // to HOLD at edge 15. STRETCH restarts at edge 16, so rst_n rises at
    // edge 32 and not at edge 20.
    for (int e = 1; e <= 32; e++) begin
      req_n[0] = (e == 1)  ? 1'b0 : 1'b1;
      req_n[1] = (e == 13) ? 1'b0 : 1'b1;
      step();
      check($sformatf("restr.rst_n@%0d", e), 8'(rst_n), 8'(e < 3 || e >= 32));
    end
    check("restr.cause", 8'(cause), 8'h01);
    $display("txn restr: request during stretch restarts stretch");

    // Hard reset asserted while in STRETCH (entered at edge 4)
    for (int e = 1; e <= 7; e++) begin
      req_n[0] = (e == 1) ? 1'b0 : 1'b1;
      reset    = (e == 7);
      step();
      if (e < 7) check($sformatf("mid.rst_n@%0d", e), 8'(rst_n), 8'(e < 3));
    end
    check_reset_values("mid");
    reset = 1'b0;
    power_up("pwr2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
